// File: rtl/ysyx_mdu_pkg.sv
// Types, constants and helpers shared by the multiply/divide request controller.
`include "ysyx.svh"

package ysyx_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_IDLE,
    MDU_ISSUE,
    MDU_WAIT,
    MDU_DONE,
    MDU_DRAIN
  } mdu_state_t;

  localparam logic [`YSYX_XLEN-1:0] MDU_INT_MIN  = {1'b1, {(`YSYX_XLEN-1){1'b0}}};
  localparam logic [`YSYX_XLEN-1:0] MDU_ALL_ONES = {`YSYX_XLEN{1'b1}};

  function automatic logic is_div_op(input logic [4:0] op);
    case (op)
      `YSYX_ALU_DIV___, `YSYX_ALU_DIVU__,
      `YSYX_ALU_REM___, `YSYX_ALU_REMU__: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_exu_mdu_ctrl_if.sv
// Issue-side request and writeback-side response handshakes of the MDU controller.
`include "ysyx.svh"

interface ysyx_exu_mdu_ctrl_if #(
  parameter int XLEN  = `YSYX_XLEN,
  parameter int TAG_W = 4
) ();

  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [4:0]       req_op;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_r;
  logic [TAG_W-1:0] rsp_tag;

  // Issue stage / writeback side.
  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_tag
  );

  // Controller side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_tag
  );

endinterface

// File: rtl/ysyx.svh
// Shared core-wide defines: datapath width and the RV32M slice of the ALU op encoding.
`ifndef YSYX_SVH
`define YSYX_SVH

`define YSYX_XLEN 32

`define YSYX_ALU_MUL___ 5'b10000
`define YSYX_ALU_MULH__ 5'b10001
`define YSYX_ALU_MULHSU 5'b10010
`define YSYX_ALU_MULHU_ 5'b10011
`define YSYX_ALU_DIV___ 5'b10100
`define YSYX_ALU_DIVU__ 5'b10101
`define YSYX_ALU_REM___ 5'b10110
`define YSYX_ALU_REMU__ 5'b10111

`endif

// File: rtl/ysyx_mdu_special.sv
// Detects M-extension cases that resolve without the unit (x/0, INT_MIN/-1, unknown op).
`include "ysyx.svh"

module ysyx_mdu_special
  import ysyx_mdu_pkg::*;
#(
  parameter int XLEN = `YSYX_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      op,
  output logic            special,
  output logic [XLEN-1:0] r
);

  logic div_zero;
  logic overflow;

  assign div_zero = is_div_op(op) && (b == '0);
  assign overflow = (a == MDU_INT_MIN) && (b == MDU_ALL_ONES);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch.
    special = 1'b0;
    r       = '0;
    case (op)
      `YSYX_ALU_DIV___, `YSYX_ALU_DIVU__: begin
        if (div_zero) begin
          special = 1'b1;
          r       = MDU_ALL_ONES;
        end else if (overflow && op == `YSYX_ALU_DIV___) begin
          special = 1'b1;
          r       = MDU_INT_MIN;
        end
      end
      `YSYX_ALU_REM___, `YSYX_ALU_REMU__: begin
        if (div_zero) begin
          special = 1'b1;
          r       = a;
        end else if (overflow && op == `YSYX_ALU_REM___) begin
          special = 1'b1;
        end
      end
      `YSYX_ALU_MUL___, `YSYX_ALU_MULH__,
      `YSYX_ALU_MULHSU, `YSYX_ALU_MULHU_: ;
      // Anything else mirrors the unit's default result of zero.
      default: special = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_exu_mdu_ctrl.sv
// Request-side controller for ysyx_exu_mul: launches one op at a time, returns result with its ROB tag.
`include "ysyx.svh"

module ysyx_exu_mdu_ctrl
  import ysyx_mdu_pkg::*;
#(
  parameter int XLEN  = `YSYX_XLEN,
  parameter int TAG_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  ysyx_exu_mdu_ctrl_if.slave io,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  output logic [4:0]      mul_op,
  output logic            mul_valid,
  input  logic [XLEN-1:0] mul_r,
  input  logic            mul_done
);

  mdu_state_t       state;
  logic [TAG_W-1:0] tag_q;
  logic             special;
  logic [XLEN-1:0]  special_r;

  ysyx_mdu_special #(.XLEN(XLEN)) u_special (
    .a       (io.req_a),
    .b       (io.req_b),
    .op      (io.req_op),
    .special (special),
    .r       (special_r)
  );

  // mul_a/mul_b/mul_op double as the latched operands, so they hold through ISSUE and WAIT.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state        <= MDU_IDLE;
      io.req_ready <= 1'b1;
      io.rsp_valid <= 1'b0;
      io.rsp_r     <= '0;
      io.rsp_tag   <= '0;
      mul_valid    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_op       <= '0;
      tag_q        <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (!flush && io.req_valid) begin
            mul_a        <= io.req_a;
            mul_b        <= io.req_b;
            mul_op       <= io.req_op;
            tag_q        <= io.req_tag;
            io.req_ready <= 1'b0;
            if (special) begin
              io.rsp_r     <= special_r;
              io.rsp_tag   <= io.req_tag;
              io.rsp_valid <= 1'b1;
              state        <= MDU_DONE;
            end else begin
              mul_valid <= 1'b1;
              state     <= MDU_ISSUE;
            end
          end
        end

        MDU_ISSUE: begin
          mul_valid <= 1'b0;
          state     <= flush ? MDU_DRAIN : MDU_WAIT;
        end

        MDU_WAIT: begin
          if (flush) begin
            // A result arriving with the flush is already retired by the unit; nothing left to drain.
            if (mul_done) begin
              io.req_ready <= 1'b1;
              state        <= MDU_IDLE;
            end else begin
              state <= MDU_DRAIN;
            end
          end else if (mul_done) begin
            io.rsp_r     <= mul_r;
            io.rsp_tag   <= tag_q;
            io.rsp_valid <= 1'b1;
            state        <= MDU_DONE;
          end
        end

        MDU_DONE: begin
          if (flush || io.rsp_ready) begin
            io.rsp_valid <= 1'b0;
            io.req_ready <= 1'b1;
            state        <= MDU_IDLE;
          end
        end

        MDU_DRAIN: begin
          if (mul_done) begin
            io.req_ready <= 1'b1;
            state        <= MDU_IDLE;
          end
        end

        default: begin
          io.req_ready <= 1'b1;
          io.rsp_valid <= 1'b0;
          mul_valid    <= 1'b0;
          state        <= MDU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_exu_mdu_ctrl.sv
// Directed bench for ysyx_exu_mdu_ctrl; the multiplier/divider is played by the stimulus itself.
module tb_ysyx_exu_mdu_ctrl;

  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_MULH  = 5'b10001;
  localparam logic [4:0] OP_MULHU = 5'b10011;
  localparam logic [4:0] OP_DIV   = 5'b10100;
  localparam logic [4:0] OP_DIVU  = 5'b10101;
  localparam logic [4:0] OP_REM   = 5'b10110;
  localparam logic [4:0] OP_REMU  = 5'b10111;
  localparam logic [4:0] OP_BAD   = 5'b00001;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [4:0]  mul_op;
  logic        mul_valid;
  logic [31:0] mul_r;
  logic        mul_done;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_exu_mdu_ctrl_if #(.XLEN(32), .TAG_W(4)) bus ();

  ysyx_exu_mdu_ctrl #(.XLEN(32), .TAG_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .io        (bus),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_op    (mul_op),
    .mul_valid (mul_valid),
    .mul_r     (mul_r),
    .mul_done  (mul_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 32'd1);
    check({tag, "_mul_valid"}, mul_valid, 32'd0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 32'd0);
    check({tag, "_rsp_r"}, bus.rsp_r, 32'd0);
    check({tag, "_rsp_tag"}, bus.rsp_tag, 32'd0);
    check({tag, "_mul_a"}, mul_a, 32'd0);
    check({tag, "_mul_b"}, mul_b, 32'd0);
    check({tag, "_mul_op"}, mul_op, 32'd0);
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = t;
  endtask

  // Locally resolved op: response one cycle after acceptance, unit never launched.
  task automatic local_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t, input logic [31:0] exp);
    send(op, a, b, t);
    tick();
    bus.req_valid = 1'b0;
    check({tag, "_rsp_valid"}, bus.rsp_valid, 32'd1);
    check({tag, "_rsp_r"}, bus.rsp_r, exp);
    check({tag, "_rsp_tag"}, bus.rsp_tag, {28'd0, t});
    check({tag, "_no_launch"}, mul_valid, 32'd0);
    tick();
    check({tag, "_ready_next"}, bus.req_ready, 32'd1);
    check({tag, "_rsp_drop"}, bus.rsp_valid, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    mul_r         = '0;
    mul_done      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    check_reset("reset");
    reset = 1'b0;

    // MUL 7*6 with the unit answering 3 cycles after launch.
    send(OP_MUL, 32'd7, 32'd6, 4'd3);
    tick();
    bus.req_valid = 1'b0;
    check("mul_launch", mul_valid, 32'd1);
    check("mul_a", mul_a, 32'd7);
    check("mul_b", mul_b, 32'd6);
    check("mul_op", mul_op, {27'd0, OP_MUL});
    check("mul_busy", bus.req_ready, 32'd0);
    tick();
    check("mul_pulse_once", mul_valid, 32'd0);
    check("mul_a_hold", mul_a, 32'd7);
    check("mul_wait1", bus.rsp_valid, 32'd0);
    tick();
    check("mul_wait2", bus.rsp_valid, 32'd0);
    tick();
    mul_done = 1'b1;
    mul_r    = 32'd42;
    check("mul_b_hold", mul_b, 32'd6);
    tick();
    mul_done = 1'b0;
    check("mul_rsp_valid", bus.rsp_valid, 32'd1);
    check("mul_rsp_r", bus.rsp_r, 32'd42);
    check("mul_rsp_tag", bus.rsp_tag, 32'd3);
    check("mul_rsp_busy", bus.req_ready, 32'd0);
    tick();
    check("mul_rsp_done", bus.rsp_valid, 32'd0);
    check("mul_ready_back", bus.req_ready, 32'd1);

    local_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 4'd5, 32'hFFFF_FFFF);
    local_op("remu_zero", OP_REMU, 32'd5, 32'd0, 4'd6, 32'd5);
    local_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 32'h8000_0000);
    local_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32'd0);
    local_op("div_zero", OP_DIV, 32'd9, 32'd0, 4'd1, 32'hFFFF_FFFF);
    local_op("rem_zero", OP_REM, 32'd9, 32'd0, 4'd2, 32'd9);
    local_op("bad_op", OP_BAD, 32'd3, 32'd4, 4'd4, 32'd0);

    // MULH -1*2 with writeback stalled for 4 cycles and a stray mul_done while in DONE.
    bus.rsp_ready = 1'b0;
    send(OP_MULH, 32'hFFFF_FFFF, 32'd2, 4'd9);
    tick();
    bus.req_valid = 1'b0;
    check("mulh_launch", mul_valid, 32'd1);
    check("mulh_op", mul_op, {27'd0, OP_MULH});
    tick();
    mul_done = 1'b1;
    mul_r    = 32'hFFFF_FFFF;
    tick();
    mul_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("mulh_stall_valid", bus.rsp_valid, 32'd1);
      check("mulh_stall_r", bus.rsp_r, 32'hFFFF_FFFF);
      check("mulh_stall_tag", bus.rsp_tag, 32'd9);
      check("mulh_stall_busy", bus.req_ready, 32'd0);
      mul_done = (i == 1);
      mul_r    = 32'h0000_1234;
      tick();
      mul_done = 1'b0;
    end
    check("mulh_still_valid", bus.rsp_valid, 32'd1);
    check("mulh_still_r", bus.rsp_r, 32'hFFFF_FFFF);
    bus.rsp_ready = 1'b1;
    tick();
    check("mulh_done", bus.rsp_valid, 32'd0);
    check("mulh_ready_back", bus.req_ready, 32'd1);

    // Flush in WAIT; the unit finishes 2 cycles after the flush and its result is dropped.
    send(OP_MUL, 32'd1, 32'd1, 4'd10);
    tick();
    bus.req_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("drain_busy", bus.req_ready, 32'd0);
    check("drain_no_rsp", bus.rsp_valid, 32'd0);
    check("drain_no_launch", mul_valid, 32'd0);
    tick();
    mul_done = 1'b1;
    mul_r    = 32'd1;
    check("drain_busy2", bus.req_ready, 32'd0);
    tick();
    mul_done = 1'b0;
    check("drain_ready_back", bus.req_ready, 32'd1);
    check("drain_dropped", bus.rsp_valid, 32'd0);
    tick();
    check("drain_no_late_rsp", bus.rsp_valid, 32'd0);

    // MULHU after the drain: 0xFFFFFFFF * 0xFFFFFFFF -> upper word 0xFFFFFFFE.
    send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11);
    tick();
    bus.req_valid = 1'b0;
    check("mulhu_launch", mul_valid, 32'd1);
    check("mulhu_a", mul_a, 32'hFFFF_FFFF);
    check("mulhu_op", mul_op, {27'd0, OP_MULHU});
    tick();
    tick();
    mul_done = 1'b1;
    mul_r    = 32'hFFFF_FFFE;
    tick();
    mul_done = 1'b0;
    check("mulhu_rsp_valid", bus.rsp_valid, 32'd1);
    check("mulhu_rsp_r", bus.rsp_r, 32'hFFFF_FFFE);
    check("mulhu_rsp_tag", bus.rsp_tag, 32'd11);
    tick();
    check("mulhu_ready_back", bus.req_ready, 32'd1);

    // Flush in WAIT coinciding with mul_done: straight back to IDLE.
    send(OP_MUL, 32'd2, 32'd3, 4'd12);
    tick();
    bus.req_valid = 1'b0;
    tick();
    flush    = 1'b1;
    mul_done = 1'b1;
    mul_r    = 32'd6;
    tick();
    flush    = 1'b0;
    mul_done = 1'b0;
    check("flush_done_ready", bus.req_ready, 32'd1);
    check("flush_done_no_rsp", bus.rsp_valid, 32'd0);

    // Flush in IDLE blocks the same-cycle request.
    send(OP_DIVU, 32'd1, 32'd0, 4'd13);
    flush = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    check("flush_idle_ready", bus.req_ready, 32'd1);
    check("flush_idle_no_rsp", bus.rsp_valid, 32'd0);
    check("flush_idle_no_launch", mul_valid, 32'd0);

    // Flush in DONE drops the pending response.
    bus.rsp_ready = 1'b0;
    send(OP_DIVU, 32'd1, 32'd0, 4'd14);
    tick();
    bus.req_valid = 1'b0;
    check("flush_done_state_valid", bus.rsp_valid, 32'd1);
    flush = 1'b1;
    tick();
    flush         = 1'b0;
    bus.rsp_ready = 1'b1;
    check("flush_rsp_dropped", bus.rsp_valid, 32'd0);
    check("flush_rsp_ready", bus.req_ready, 32'd1);

    // Reset in WAIT, then a late mul_done that must be ignored.
    send(OP_MUL, 32'd3, 32'd4, 4'd15);
    tick();
    bus.req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset("rst_wait");
    mul_done = 1'b1;
    mul_r    = 32'd12;
    tick();
    mul_done = 1'b0;
    check("late_done_no_rsp", bus.rsp_valid, 32'd0);
    check("late_done_ready", bus.req_ready, 32'd1);
    check("late_done_no_launch", mul_valid, 32'd0);
    tick();
    check("late_done_quiet", bus.rsp_valid, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
